// File: rtl/issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// issue_ctrl_pkg
// Shared pipeline definitions for the issue controller and its register
// scoreboard: issue FSM state type, register-file geometry, stall counter
// ceiling and a write-enable decode helper that never selects x0.
// No ports (package).
// -----------------------------------------------------------------------------
package issue_ctrl_pkg;

   localparam int unsigned REG_COUNT = 32;
   localparam int unsigned REG_AW    = 5;

   localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      CTRL_WAIT = 2'd1,
      FLUSH     = 2'd2
   } issue_state_t;

   // One-hot decode of a register address, qualified by an enable.
   // Bit 0 is never produced: x0 is hardwired and never tracked.
   function automatic logic [REG_COUNT-1:0] reg_onehot_nz(
      input logic [REG_AW-1:0] addr,
      input logic              en
   );
      logic [REG_COUNT-1:0] mask;
      mask = {REG_COUNT{1'b0}};
      if (en && (addr != {REG_AW{1'b0}})) begin
         mask[addr] = 1'b1;
      end else begin
         mask = {REG_COUNT{1'b0}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/issue_ctrl_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_ctrl_reg_scoreboard
// 32-entry pending-write bitmap. A set marks a register as having an
// in-flight write, a clear retires it. x0 is never set or cleared. When the
// same register is set and cleared in one cycle the set wins, because the
// set belongs to the newer instruction.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   set_en, set_addr    mark register busy at next edge
//   clr_en, clr_addr    retire register at next edge
//   rs1_addr, rs2_addr  read ports -> rs1_busy, rs2_busy
//   rd_addr             destination check -> rd_busy
//   pending             registered bitmap (bit 0 always 0)
// -----------------------------------------------------------------------------
module issue_ctrl_reg_scoreboard
   import issue_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 set_en,
   input  logic [REG_AW-1:0]    set_addr,
   input  logic                 clr_en,
   input  logic [REG_AW-1:0]    clr_addr,
   input  logic [REG_AW-1:0]    rs1_addr,
   input  logic [REG_AW-1:0]    rs2_addr,
   input  logic [REG_AW-1:0]    rd_addr,
   output logic                 rs1_busy,
   output logic                 rs2_busy,
   output logic                 rd_busy,
   output logic [REG_COUNT-1:0] pending
);

   logic [REG_COUNT-1:0] pending_q;
   logic [REG_COUNT-1:0] pending_d;
   logic [REG_COUNT-1:0] set_mask;
   logic [REG_COUNT-1:0] clr_mask;

   // Next bitmap: clear first, then OR in the set so a same-cycle set wins.
   always_comb begin
      set_mask  = reg_onehot_nz(set_addr, set_en);
      clr_mask  = reg_onehot_nz(clr_addr, clr_en);
      pending_d = (pending_q & ~clr_mask) | set_mask;
      // x0 can never become pending, even if the register were disturbed.
      pending_d[0] = 1'b0;
   end

   // Bitmap register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= {REG_COUNT{1'b0}};
      end else begin
         pending_q <= pending_d;
      end
   end

   // Read ports use only the registered bitmap (no writeback bypass).
   always_comb begin
      rs1_busy = pending_q[rs1_addr];
      rs2_busy = pending_q[rs2_addr];
      rd_busy  = pending_q[rd_addr];
      pending  = pending_q;
   end

endmodule

// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl
// Issue controller between decode and execute. Stalls decode on RAW/WAW
// hazards using a register scoreboard, holds issue while a jump/branch
// resolves, discards FLUSH_CYCLES cycles of wrong-path fetch/decode after a
// taken redirect, and counts stalled decode cycles (saturating).
// Parameters:
//   FLUSH_CYCLES   cycles of wrong-path discard after a taken redirect (>=1)
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   id_valid / id_ready           decode handshake
//   rs1_addr, rs2_addr, rd_addr   operands / destination (0 = none)
//   is_ctrl                       decoded instruction is jump/branch
//   ex_ready / issue_valid        execute handshake
//   wb_valid, wb_addr             writeback retiring a register
//   resolve_valid, resolve_taken  control resolution from execute
//   flush                         discard fetch/decode contents
//   pending                       scoreboard bitmap
//   stall_count                   saturating stall-cycle counter
// -----------------------------------------------------------------------------
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_valid,
   output logic                 id_ready,
   input  logic [REG_AW-1:0]    rs1_addr,
   input  logic [REG_AW-1:0]    rs2_addr,
   input  logic [REG_AW-1:0]    rd_addr,
   input  logic                 is_ctrl,
   input  logic                 ex_ready,
   output logic                 issue_valid,
   input  logic                 wb_valid,
   input  logic [REG_AW-1:0]    wb_addr,
   input  logic                 resolve_valid,
   input  logic                 resolve_taken,
   output logic                 flush,
   output logic [REG_COUNT-1:0] pending,
   output logic [31:0]          stall_count
);

   localparam int unsigned CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
   localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

   issue_state_t  state_q;
   issue_state_t  state_d;
   logic [CW-1:0] flush_cnt_q;
   logic [CW-1:0] flush_cnt_d;
   logic [31:0]   stall_count_q;
   logic [31:0]   stall_count_d;

   logic          rs1_busy;
   logic          rs2_busy;
   logic          rd_busy;
   logic          hazard;
   logic          stall_cycle;

   issue_ctrl_reg_scoreboard u_scoreboard (
      .clk      (clk),
      .rst      (reset),
      .set_en   (issue_valid),
      .set_addr (rd_addr),
      .clr_en   (wb_valid),
      .clr_addr (wb_addr),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rd_addr  (rd_addr),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .rd_busy  (rd_busy),
      .pending  (pending)
   );

   // Handshake outputs, next state and flush counter.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      id_ready    = 1'b0;
      issue_valid = 1'b0;
      flush       = 1'b0;
      stall_cycle = 1'b0;
      // Unused address fields are 0, and x0 is never pending, so no
      // per-operand qualification is needed.
      hazard      = rs1_busy | rs2_busy | rd_busy;

      case (state_q)
         RUN: begin
            id_ready    = ex_ready & ~hazard;
            issue_valid = id_valid & id_ready;
            stall_cycle = id_valid & ~id_ready;
            // resolve_valid here belongs to nothing we are waiting on.
            if (issue_valid && is_ctrl) begin
               state_d = CTRL_WAIT;
            end else begin
               state_d = RUN;
            end
         end
         CTRL_WAIT: begin
            stall_cycle = id_valid;
            if (resolve_valid && resolve_taken) begin
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_LOAD;
            end else if (resolve_valid) begin
               state_d = RUN;
            end else begin
               state_d = CTRL_WAIT;
            end
         end
         FLUSH: begin
            // Accept and drop whatever decode holds: it is wrong-path.
            flush    = 1'b1;
            id_ready = 1'b1;
            // A counter of 0 cannot occur legally; treat it as the last cycle.
            if (flush_cnt_q <= CNT_ONE) begin
               state_d     = RUN;
               flush_cnt_d = CNT_ZERO;
            end else begin
               state_d     = FLUSH;
               flush_cnt_d = flush_cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d     = RUN;
            flush_cnt_d = CNT_ZERO;
         end
      endcase
   end

   // Saturating stall counter next value.
   always_comb begin
      if (stall_cycle && (stall_count_q != STALL_MAX)) begin
         stall_count_d = stall_count_q + 32'd1;
      end else begin
         stall_count_d = stall_count_q;
      end
   end

   // FSM state, flush counter and stall counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         flush_cnt_q   <= CNT_ZERO;
         stall_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Counter is exposed straight from its register.
   always_comb begin
      stall_count = stall_count_q;
   end

endmodule

// File: tb/tb_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_issue_ctrl
// Directed scenarios followed by random traffic, every cycle compared with a
// behavioural model of the issue rules (pending set, mode, flush cycles left,
// stall total).
// -----------------------------------------------------------------------------
module tb_issue_ctrl;

   localparam int unsigned F = 2;

   logic        clk;
   logic        reset;
   logic        id_valid;
   logic        id_ready;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic        is_ctrl;
   logic        ex_ready;
   logic        issue_valid;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic        resolve_valid;
   logic        resolve_taken;
   logic        flush;
   logic [31:0] pending;
   logic [31:0] stall_count;

   issue_ctrl #(.FLUSH_CYCLES(F)) dut (
      .clk           (clk),
      .reset         (reset),
      .id_valid      (id_valid),
      .id_ready      (id_ready),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rd_addr       (rd_addr),
      .is_ctrl       (is_ctrl),
      .ex_ready      (ex_ready),
      .issue_valid   (issue_valid),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .resolve_valid (resolve_valid),
      .resolve_taken (resolve_taken),
      .flush         (flush),
      .pending       (pending),
      .stall_count   (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Model: "waiting" = a control instruction is unresolved,
   // flush_left = wrong-path cycles still to discard.
   bit [31:0]       m_pend;
   bit              m_waiting;
   int              m_flush_left;
   longint unsigned m_stall;
   bit              e_ready;
   bit              e_issue;
   bit              e_flush;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend       = 32'd0;
      m_waiting    = 1'b0;
      m_flush_left = 0;
      m_stall      = 64'd0;
   endtask

   task automatic model_expect();
      bit haz;
      haz     = m_pend[rs1_addr] | m_pend[rs2_addr] | m_pend[rd_addr];
      e_flush = (m_flush_left > 0);
      if (e_flush)        e_ready = 1'b1;
      else if (m_waiting) e_ready = 1'b0;
      else                e_ready = ex_ready && !haz;
      e_issue = id_valid && e_ready && !e_flush;
   endtask

   task automatic model_advance();
      if (id_valid && !e_ready && !e_flush && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (wb_valid && wb_addr != 5'd0) m_pend[wb_addr] = 1'b0;
      if (e_issue && rd_addr != 5'd0)  m_pend[rd_addr] = 1'b1;
      if (e_flush) begin
         m_flush_left--;
      end else if (m_waiting) begin
         if (resolve_valid) begin
            m_waiting = 1'b0;
            if (resolve_taken) m_flush_left = F;
         end
      end else if (e_issue && is_ctrl) begin
         m_waiting = 1'b1;
      end
   endtask

   // Inputs are already driven (at a negedge); check, clock, advance model.
   task automatic step();
      #1;
      model_expect();
      chk("id_ready",    {31'd0, id_ready},    {31'd0, e_ready});
      chk("issue_valid", {31'd0, issue_valid}, {31'd0, e_issue});
      chk("flush",       {31'd0, flush},       {31'd0, e_flush});
      chk("pending",     pending,              m_pend);
      chk("stall_count", stall_count,          m_stall[31:0]);
      @(posedge clk);
      model_advance();
      @(negedge clk);
   endtask

   task automatic idle();
      id_valid      = 1'b0;
      rs1_addr      = 5'd0;
      rs2_addr      = 5'd0;
      rd_addr       = 5'd0;
      is_ctrl       = 1'b0;
      ex_ready      = 1'b1;
      wb_valid      = 1'b0;
      wb_addr       = 5'd0;
      resolve_valid = 1'b0;
      resolve_taken = 1'b0;
   endtask

   task automatic instr(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d, input logic c);
      id_valid = 1'b1;
      rs1_addr = s1;
      rs2_addr = s2;
      rd_addr  = d;
      is_ctrl  = c;
   endtask

   initial begin
      idle();
      model_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_pending", pending, 32'd0);
      chk("rst_stall",   stall_count, 32'd0);
      chk("rst_flush",   {31'd0, flush}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // RAW on x5: stall until the cycle after writeback.
      instr(5'd0, 5'd0, 5'd5, 1'b0); step();
      idle(); instr(5'd5, 5'd0, 5'd6, 1'b0);
      repeat (3) step();
      wb_valid = 1'b1; wb_addr = 5'd5; step();
      chk("raw_stalls", stall_count, 32'd4);
      wb_valid = 1'b0; step();
      chk("raw_pending6", pending, 32'h0000_0040);
      idle(); wb_valid = 1'b1; wb_addr = 5'd6; step();

      // WAW on x7, then a write to x0 leaves nothing pending.
      idle(); instr(5'd0, 5'd0, 5'd7, 1'b0); step();
      instr(5'd1, 5'd2, 5'd7, 1'b0); repeat (2) step();
      idle(); wb_valid = 1'b1; wb_addr = 5'd7; step();
      idle(); instr(5'd0, 5'd0, 5'd0, 1'b0); step();
      chk("x0_pending", pending, 32'd0);
      instr(5'd0, 5'd0, 5'd0, 1'b0); step();

      // Same-cycle set and clear of x3: set wins.
      idle(); instr(5'd0, 5'd0, 5'd3, 1'b0); step();
      idle(); instr(5'd0, 5'd0, 5'd3, 1'b0); wb_valid = 1'b1; wb_addr = 5'd3;
      ex_ready = 1'b1;
      // x3 is pending so this one stalls; retire it first then re-issue with clear.
      step();
      idle(); instr(5'd0, 5'd0, 5'd3, 1'b0); wb_valid = 1'b1; wb_addr = 5'd3; step();
      chk("setwins_p3", {31'd0, pending[3]}, 32'd1);
      idle(); wb_valid = 1'b1; wb_addr = 5'd3; step();

      // Taken branch issued at t, resolved at t+3.
      idle(); instr(5'd0, 5'd0, 5'd0, 1'b1); step();
      idle(); instr(5'd0, 5'd0, 5'd9, 1'b0); step(); step();
      resolve_valid = 1'b1; resolve_taken = 1'b1; step();
      resolve_valid = 1'b0; resolve_taken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("br_flush", {31'd0, flush}, 32'd1);
         chk("br_ready", {31'd0, id_ready}, 32'd1);
         chk("br_noissue", {31'd0, issue_valid}, 32'd0);
         #1;
         step();
      end
      #1;
      chk("br_resume", {31'd0, issue_valid}, 32'd1);
      step();
      idle(); wb_valid = 1'b1; wb_addr = 5'd9; step();

      // Not-taken branch, resolved at t+1; resolve at issue cycle ignored.
      idle(); instr(5'd0, 5'd0, 5'd0, 1'b1); resolve_valid = 1'b1; step();
      idle(); resolve_valid = 1'b1; step();
      idle(); instr(5'd0, 5'd0, 5'd0, 1'b0);
      #1;
      chk("nt_resume", {31'd0, issue_valid}, 32'd1);
      chk("nt_noflush", {31'd0, flush}, 32'd0);
      #1;
      step();

      // Reset in the middle of FLUSH with x3 and x5 pending.
      idle(); instr(5'd0, 5'd0, 5'd3, 1'b0); step();
      instr(5'd0, 5'd0, 5'd5, 1'b1); step();
      idle(); resolve_valid = 1'b1; resolve_taken = 1'b1; step();
      idle(); #1;
      chk("pre_rst_pending", pending, 32'h0000_0028);
      chk("pre_rst_flush", {31'd0, flush}, 32'd1);
      reset = 1'b1;
      #1;
      model_reset();
      chk("arst_pending", pending, 32'd0);
      chk("arst_flush", {31'd0, flush}, 32'd0);
      chk("arst_stall", stall_count, 32'd0);
      chk("arst_run", {31'd0, id_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Saturation from a preloaded count.
      force dut.stall_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_count_q;
      m_stall = 64'hFFFF_FFFE;
      idle(); instr(5'd0, 5'd0, 5'd0, 1'b0); ex_ready = 1'b0;
      repeat (3) step();
      #1;
      chk("sat_hold", stall_count, 32'hFFFF_FFFF);
      #1;

      // Random traffic on a small register window to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         id_valid      = ($urandom_range(3) != 0);
         rs1_addr      = 5'($urandom_range(7));
         rs2_addr      = 5'($urandom_range(7));
         rd_addr       = 5'($urandom_range(7));
         is_ctrl       = ($urandom_range(7) == 0);
         ex_ready      = ($urandom_range(3) != 0);
         wb_valid      = ($urandom_range(1) == 1);
         wb_addr       = 5'($urandom_range(7));
         resolve_valid = ($urandom_range(2) == 0);
         resolve_taken = ($urandom_range(1) == 1);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
